// File: rtl/neuron_driver_pkg.sv
// rtl/neuron_driver_pkg.sv - shared constants, FSM encoding and index-width helper for neuron blocks
package neuron_driver_pkg;

    // Default fixed-point format shared by the neuron datapath blocks.
    localparam int unsigned NEURON_WIDTH     = 8;
    localparam int unsigned NEURON_FRAC_BITS = 3;

    // Driver FSM encoding (2 bits).
    localparam logic [1:0] ST_LOAD    = 2'd0;
    localparam logic [1:0] ST_FIRE    = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_PRESENT = 2'd3;

    // ceil(log2(n)), never less than 1, so a single-slot or single-count
    // index still gets a real bit.
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((32'd1 << w) < n) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/neuron_driver_packer.sv
// rtl/neuron_driver_packer.sv - slot-indexed value/weight vector register with zero-fill
//
// Ports:
//   clk_i, rstn_i          clock, synchronous active-low reset (clears both vectors)
//   wr_en_i                accept one (value, weight) pair this cycle
//   zero_fill_i            with wr_en_i: clear every slot above wr_idx_i
//   wr_idx_i               target slot
//   wr_value_i/wr_weight_i pair written into the slot
//   values_o/weights_o     packed vectors, slot i = bits [i*WIDTH +: WIDTH]
module neuron_driver_packer
    import neuron_driver_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned WIDTH      = NEURON_WIDTH,
    parameter int unsigned IDX_W      = idx_width(NUM_INPUTS)
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        wr_en_i,
    input  logic                        zero_fill_i,
    input  logic [IDX_W-1:0]            wr_idx_i,
    input  logic [WIDTH-1:0]            wr_value_i,
    input  logic [WIDTH-1:0]            wr_weight_i,
    output logic [NUM_INPUTS*WIDTH-1:0] values_o,
    output logic [NUM_INPUTS*WIDTH-1:0] weights_o
);

    logic [NUM_INPUTS*WIDTH-1:0] values_q, values_d;
    logic [NUM_INPUTS*WIDTH-1:0] weights_q, weights_d;

    // Slots are only touched on an accepted beat, so the vectors stay
    // stable while the neuron consumes them.
    always_comb begin
        values_d  = values_q;
        weights_d = weights_q;
        if (wr_en_i) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                if (wr_idx_i == IDX_W'(i)) begin
                    values_d[i*WIDTH +: WIDTH]  = wr_value_i;
                    weights_d[i*WIDTH +: WIDTH] = wr_weight_i;
                end else if (zero_fill_i && (IDX_W'(i) > wr_idx_i)) begin
                    // Short transaction: stale data from the previous
                    // transaction must not leak into unused slots.
                    values_d[i*WIDTH +: WIDTH]  = '0;
                    weights_d[i*WIDTH +: WIDTH] = '0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            values_q  <= '0;
            weights_q <= '0;
        end else begin
            values_q  <= values_d;
            weights_q <= weights_d;
        end
    end

    assign values_o  = values_q;
    assign weights_o = weights_q;

endmodule

// File: rtl/neuron_driver.sv
// rtl/neuron_driver.sv - packs a (value, weight) stream for a neuron, fires it and returns the result
//
// Optional feature macro: NEURON_DRIVER_TIMEOUT_EN (WAIT watchdog; RESULT_TIMEOUT tied 0 without it)
//
// Ports:
//   CLK, RSTN                      clock, synchronous active-low reset
//   S_VALUE/S_WEIGHT/S_BIAS        streamed pair, bias taken on beat 0
//   S_LAST/S_VALID/S_READY         stream framing and handshake
//   VALUES_OUT/WEIGHTS_OUT         packed vectors to the neuron
//   BIAS_OUT, VALID_OUT            latched bias, one-cycle fire pulse
//   NEURON_VALUE_IN/_VALID_IN/_OVERFLOW_IN  neuron result interface
//   RESULT/RESULT_VALID/RESULT_READY        downstream result handshake
//   RESULT_OVERFLOW, RESULT_TIMEOUT         per-transaction status
//   PROTO_ERR                      sticky framing error (missing S_LAST)
module neuron_driver
    import neuron_driver_pkg::*;
#(
    parameter int unsigned NUM_INPUTS     = 4,
    parameter int unsigned WIDTH          = NEURON_WIDTH,
    parameter int unsigned FRAC_BITS      = NEURON_FRAC_BITS,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                        CLK,
    input  logic                        RSTN,
    input  logic [WIDTH-1:0]            S_VALUE,
    input  logic [WIDTH-1:0]            S_WEIGHT,
    input  logic [WIDTH-1:0]            S_BIAS,
    input  logic                        S_LAST,
    input  logic                        S_VALID,
    output logic                        S_READY,
    output logic [NUM_INPUTS*WIDTH-1:0] VALUES_OUT,
    output logic [NUM_INPUTS*WIDTH-1:0] WEIGHTS_OUT,
    output logic [WIDTH-1:0]            BIAS_OUT,
    output logic                        VALID_OUT,
    input  logic [WIDTH-1:0]            NEURON_VALUE_IN,
    input  logic                        NEURON_VALID_IN,
    input  logic                        NEURON_OVERFLOW_IN,
    output logic [WIDTH-1:0]            RESULT,
    output logic                        RESULT_VALID,
    input  logic                        RESULT_READY,
    output logic                        RESULT_OVERFLOW,
    output logic                        RESULT_TIMEOUT,
    output logic                        PROTO_ERR
);

    localparam int unsigned      IDX_W    = idx_width(NUM_INPUTS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_INPUTS - 1);

    // Format parameters are carried for the neuron; reject nonsense early.
    if (NUM_INPUTS < 1 || FRAC_BITS >= WIDTH || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("neuron_driver: invalid NUM_INPUTS/FRAC_BITS/TIMEOUT_CYCLES");
    end

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] bias_q, bias_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ovf_q, ovf_d;
    logic             first_present_q, first_present_d;
    logic             proto_err_q, proto_err_d;
    logic             beat;

`ifdef NEURON_DRIVER_TIMEOUT_EN
    localparam int unsigned     CNT_W    = idx_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    assign beat = S_VALID && (state_q == ST_LOAD);

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        bias_d          = bias_q;
        result_d        = result_q;
        ovf_d           = ovf_q;
        first_present_d = 1'b0;
        proto_err_d     = proto_err_q;
`ifdef NEURON_DRIVER_TIMEOUT_EN
        cnt_d           = cnt_q;
        timeout_d       = timeout_q;
`endif
        case (state_q)
            ST_LOAD: begin
                if (beat) begin
                    if (idx_q == '0) begin
                        bias_d = S_BIAS;
                    end
                    if (S_LAST || (idx_q == LAST_IDX)) begin
                        // A full vector without S_LAST is flagged but still
                        // fired so the layer keeps moving.
                        state_d = ST_FIRE;
                        if (!S_LAST) begin
                            proto_err_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_FIRE: begin
                ovf_d   = 1'b0;
                state_d = ST_WAIT;
`ifdef NEURON_DRIVER_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
                ovf_d = ovf_q | NEURON_OVERFLOW_IN;
                if (NEURON_VALID_IN) begin
                    result_d        = NEURON_VALUE_IN;
                    state_d         = ST_PRESENT;
                    first_present_d = 1'b1;
                end
`ifdef NEURON_DRIVER_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    result_d        = '0;
                    timeout_d       = 1'b1;
                    state_d         = ST_PRESENT;
                    first_present_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_PRESENT: begin
                // Neurons that register their overflow flag raise it one
                // cycle after the result; keep listening for that cycle.
                if (first_present_q) begin
                    ovf_d = ovf_q | NEURON_OVERFLOW_IN;
                end
                if (RESULT_READY) begin
                    state_d   = ST_LOAD;
                    idx_d     = '0;
`ifdef NEURON_DRIVER_TIMEOUT_EN
                    timeout_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q         <= ST_LOAD;
            idx_q           <= '0;
            bias_q          <= '0;
            result_q        <= '0;
            ovf_q           <= 1'b0;
            first_present_q <= 1'b0;
            proto_err_q     <= 1'b0;
`ifdef NEURON_DRIVER_TIMEOUT_EN
            cnt_q           <= '0;
            timeout_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            bias_q          <= bias_d;
            result_q        <= result_d;
            ovf_q           <= ovf_d;
            first_present_q <= first_present_d;
            proto_err_q     <= proto_err_d;
`ifdef NEURON_DRIVER_TIMEOUT_EN
            cnt_q           <= cnt_d;
            timeout_q       <= timeout_d;
`endif
        end
    end

    neuron_driver_packer #(
        .NUM_INPUTS (NUM_INPUTS),
        .WIDTH      (WIDTH),
        .IDX_W      (IDX_W)
    ) u_packer (
        .clk_i       (CLK),
        .rstn_i      (RSTN),
        .wr_en_i     (beat),
        .zero_fill_i (S_LAST),
        .wr_idx_i    (idx_q),
        .wr_value_i  (S_VALUE),
        .wr_weight_i (S_WEIGHT),
        .values_o    (VALUES_OUT),
        .weights_o   (WEIGHTS_OUT)
    );

    assign S_READY         = (state_q == ST_LOAD);
    assign VALID_OUT       = (state_q == ST_FIRE);
    assign RESULT_VALID    = (state_q == ST_PRESENT);
    assign BIAS_OUT        = bias_q;
    assign RESULT          = result_q;
    assign RESULT_OVERFLOW = ovf_q;
    assign PROTO_ERR       = proto_err_q;
`ifdef NEURON_DRIVER_TIMEOUT_EN
    assign RESULT_TIMEOUT  = timeout_q;
`else
    assign RESULT_TIMEOUT  = 1'b0;
`endif

endmodule

// File: tb/tb_neuron_driver.sv
// tb/tb_neuron_driver.sv - scoreboard bench for neuron_driver
module tb_neuron_driver;

    logic        CLK = 1'b0;
    logic        RSTN = 1'b0;
    logic [7:0]  S_VALUE = '0, S_WEIGHT = '0, S_BIAS = '0;
    logic        S_LAST = 1'b0, S_VALID = 1'b0;
    logic        S_READY;
    logic [31:0] VALUES_OUT, WEIGHTS_OUT;
    logic [7:0]  BIAS_OUT;
    logic        VALID_OUT;
    logic [7:0]  NEURON_VALUE_IN = '0;
    logic        NEURON_VALID_IN = 1'b0, NEURON_OVERFLOW_IN = 1'b0;
    logic [7:0]  RESULT;
    logic        RESULT_VALID;
    logic        RESULT_READY = 1'b0;
    logic        RESULT_OVERFLOW, RESULT_TIMEOUT, PROTO_ERR;

    neuron_driver #(
        .NUM_INPUTS(4), .WIDTH(8), .FRAC_BITS(3), .TIMEOUT_CYCLES(64)
    ) dut (
        .CLK(CLK), .RSTN(RSTN),
        .S_VALUE(S_VALUE), .S_WEIGHT(S_WEIGHT), .S_BIAS(S_BIAS),
        .S_LAST(S_LAST), .S_VALID(S_VALID), .S_READY(S_READY),
        .VALUES_OUT(VALUES_OUT), .WEIGHTS_OUT(WEIGHTS_OUT),
        .BIAS_OUT(BIAS_OUT), .VALID_OUT(VALID_OUT),
        .NEURON_VALUE_IN(NEURON_VALUE_IN), .NEURON_VALID_IN(NEURON_VALID_IN),
        .NEURON_OVERFLOW_IN(NEURON_OVERFLOW_IN),
        .RESULT(RESULT), .RESULT_VALID(RESULT_VALID), .RESULT_READY(RESULT_READY),
        .RESULT_OVERFLOW(RESULT_OVERFLOW), .RESULT_TIMEOUT(RESULT_TIMEOUT),
        .PROTO_ERR(PROTO_ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [31:0] v; logic [31:0] w; logic [7:0] b; } fire_t;
    typedef struct { logic [7:0] r; logic ovf; logic to; } res_t;

    fire_t fire_q[$];
    res_t  res_q[$];
    int    n_vec = 0;
    int    n_err = 0;
    int    n_fire = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fire-side scoreboard: every VALID_OUT pulse must match the oldest
    // transaction the stimulus pushed, and last exactly one cycle.
    logic prev_fire = 1'b0;
    always @(negedge CLK) begin
        if (RSTN && VALID_OUT) begin
            n_fire++;
            if (prev_fire) check("fire_width", VALID_OUT, 1'b0);
            if (fire_q.size() == 0) begin
                check("fire_unexpected", VALID_OUT, 1'b0);
            end else begin
                fire_t e;
                e = fire_q.pop_front();
                check("values_out", VALUES_OUT, e.v);
                check("weights_out", WEIGHTS_OUT, e.w);
                check("bias_out", BIAS_OUT, e.b);
            end
        end
        prev_fire = RSTN && VALID_OUT;
    end

    task automatic send_txn(input logic [31:0] v, input logic [31:0] w,
                            input logic [7:0] b, input int n, input bit last);
        fire_t e;
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < n; i++) m[i*8 +: 8] = 8'hFF;
        e.v = v & m;
        e.w = w & m;
        e.b = b;
        fire_q.push_back(e);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            while (!S_READY && t < 200) begin
                @(negedge CLK);
                t++;
            end
            if (!S_READY) check("sready_wait", S_READY, 1'b1);
            S_VALUE  = v[i*8 +: 8];
            S_WEIGHT = w[i*8 +: 8];
            S_BIAS   = (i == 0) ? b : ~b;
            S_LAST   = last && (i == n - 1);
            S_VALID  = 1'b1;
            @(negedge CLK);
        end
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
    endtask

    // Model neuron: answers lat cycles after the fire pulse; late_ovf raises
    // the overflow flag on the cycle after the result.
    task automatic respond(input int lat, input logic [7:0] val, input bit late_ovf);
        res_t e;
        int t;
        t = 0;
        while (!VALID_OUT && t < 200) begin
            @(negedge CLK);
            t++;
        end
        if (!VALID_OUT) begin
            check("fire_wait", VALID_OUT, 1'b1);
            return;
        end
        repeat (lat) @(negedge CLK);
        e.r = val;
        e.ovf = late_ovf;
        e.to = 1'b0;
        res_q.push_back(e);
        NEURON_VALUE_IN = val;
        NEURON_VALID_IN = 1'b1;
        @(negedge CLK);
        NEURON_VALID_IN = 1'b0;
        NEURON_VALUE_IN = $urandom_range(0, 255);
        if (late_ovf) begin
            NEURON_OVERFLOW_IN = 1'b1;
            @(negedge CLK);
            NEURON_OVERFLOW_IN = 1'b0;
        end
    endtask

    task automatic collect(input int hold, input bit stall);
        res_t e;
        int t;
        t = 0;
        while (!RESULT_VALID && t < 300) begin
            @(negedge CLK);
            t++;
        end
        if (!RESULT_VALID) begin
            check("rvalid_wait", RESULT_VALID, 1'b1);
            return;
        end
        @(negedge CLK);
        if (res_q.size() == 0) begin
            check("result_unexpected", RESULT_VALID, 1'b0);
            return;
        end
        e = res_q.pop_front();
        check("result", RESULT, e.r);
        check("result_ovf", RESULT_OVERFLOW, e.ovf);
        check("result_timeout", RESULT_TIMEOUT, e.to);
        if (stall) begin
            S_VALID = 1'b1;
            S_VALUE = 8'hEE;
            S_LAST  = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge CLK);
            check("hold_result", RESULT, e.r);
            check("hold_rvalid", RESULT_VALID, 1'b1);
            check("hold_sready", S_READY, 1'b0);
        end
        S_VALID = 1'b0;
        S_LAST  = 1'b0;
        RESULT_READY = 1'b1;
        @(negedge CLK);
        RESULT_READY = 1'b0;
        check("post_hs_rvalid", RESULT_VALID, 1'b0);
        check("post_hs_sready", S_READY, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] last_res;
        repeat (3) @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        check("rst_sready", S_READY, 1'b1);
        check("rst_valid_out", VALID_OUT, 1'b0);
        check("rst_rvalid", RESULT_VALID, 1'b0);
        check("rst_result", RESULT, 8'h00);
        check("rst_values", VALUES_OUT, 32'h0);
        check("rst_weights", WEIGHTS_OUT, 32'h0);
        check("rst_bias", BIAS_OUT, 8'h00);
        check("rst_proto", PROTO_ERR, 1'b0);
        check("rst_ovf", RESULT_OVERFLOW, 1'b0);
        check("rst_timeout", RESULT_TIMEOUT, 1'b0);

        // Basic transaction: values 8,16,-8,4, weights all 8, bias 0.
        send_txn({8'h04, 8'hF8, 8'h10, 8'h08}, 32'h08080808, 8'h00, 4, 1'b1);
        respond(3, 8'h14, 1'b0);
        collect(0, 1'b0);
        check("t1_proto", PROTO_ERR, 1'b0);

        // Early S_LAST on beat 1: slots 2-3 zero-filled over stale data.
        send_txn({8'hAA, 8'hBB, 8'h08, 8'h08}, {8'h77, 8'h66, 8'h05, 8'h03}, 8'h21, 2, 1'b1);
        respond(2, 8'h3C, 1'b0);
        collect(0, 1'b0);
        check("t2_proto", PROTO_ERR, 1'b0);

        // Missing S_LAST: still fires, PROTO_ERR sticks.
        send_txn(32'h11223344, 32'h55667788, 8'h09, 4, 1'b0);
        respond(1, 8'h42, 1'b0);
        collect(0, 1'b0);
        check("t3_proto", PROTO_ERR, 1'b1);

        // Good transaction with 10 cycles of result backpressure and a
        // stream trying to push in meanwhile.
        send_txn($urandom, $urandom, 8'h5A, 4, 1'b1);
        respond(4, 8'h81, 1'b0);
        collect(10, 1'b1);
        check("t4_proto_sticky", PROTO_ERR, 1'b1);

        // Overflow flag arriving one cycle after the result.
        send_txn($urandom, $urandom, 8'hC3, 4, 1'b1);
        respond(3, 8'h7F, 1'b1);
        collect(2, 1'b0);
        last_res = 8'h7F;

        // Spurious neuron valid while idle in LOAD.
        NEURON_VALID_IN = 1'b1;
        NEURON_VALUE_IN = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("spur_sready", S_READY, 1'b1);
            check("spur_rvalid", RESULT_VALID, 1'b0);
            check("spur_result", RESULT, last_res);
        end
        NEURON_VALID_IN = 1'b0;

        // Reset after two beats of a partial transaction.
        for (int i = 0; i < 2; i++) begin
            S_VALUE = 8'h99; S_WEIGHT = 8'h98; S_BIAS = 8'h97; S_VALID = 1'b1;
            @(negedge CLK);
        end
        S_VALID = 1'b0;
        RSTN = 1'b0;
        @(negedge CLK);
        RSTN = 1'b1;
        check("mid_rst_values", VALUES_OUT, 32'h0);
        check("mid_rst_bias", BIAS_OUT, 8'h00);
        check("mid_rst_proto", PROTO_ERR, 1'b0);
        check("mid_rst_sready", S_READY, 1'b1);
        repeat (3) @(negedge CLK);
        send_txn({8'h01, 8'h02, 8'h03, 8'h04}, {8'h10, 8'h20, 8'h30, 8'h40}, 8'h0F, 4, 1'b1);
        respond(2, 8'h66, 1'b0);
        collect(0, 1'b0);

`ifdef NEURON_DRIVER_TIMEOUT_EN
        begin
            res_t e;
            int t;
            send_txn($urandom, $urandom, 8'h44, 4, 1'b1);
            t = 0;
            while (!VALID_OUT && t < 200) begin
                @(negedge CLK);
                t++;
            end
            e.r = 8'h00; e.ovf = 1'b0; e.to = 1'b1;
            res_q.push_back(e);
            t = 0;
            while (!RESULT_VALID && t < 300) begin
                @(negedge CLK);
                t++;
            end
            // One FIRE cycle plus 64 silent WAIT cycles.
            check("timeout_latency", t, 65);
            collect(3, 1'b0);
            check("timeout_cleared", RESULT_TIMEOUT, 1'b0);
        end
`endif

        repeat (3) @(negedge CLK);
        check("fire_q_drained", fire_q.size(), 0);
        check("res_q_drained", res_q.size(), 0);
`ifdef NEURON_DRIVER_TIMEOUT_EN
        check("fire_count", n_fire, 7);
`else
        check("fire_count", n_fire, 6);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/neuron_driver.md
Name: neuron_driver

Overview:
- Initiator side of the neuron parallel-input interface.
- Accepts a serial stream of (value, weight) pairs plus a bias.
- Packs the stream into the NUM_INPUTS-wide value and weight vectors and fires a one-cycle valid pulse into a neuron.
- Waits for the neuron's result, then presents it downstream on a valid/ready handshake.
- Sits between a layer sequencer or memory reader and each neuron instance.

Parameters:
- NUM_INPUTS, 4, neuron fan-in; number of pairs per transaction.
- WIDTH, 8, fixed-point word width.
- FRAC_BITS, 3, fractional bits; pass-through only, no arithmetic here.
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- CLK  in  1  clock.
- RSTN  in  1  reset: one clock; reset is synchronous and active-low.
- S_VALUE  in  WIDTH  streamed input value.
- S_WEIGHT  in  WIDTH  streamed weight.
- S_BIAS  in  WIDTH  bias; sampled on beat 0 only.
- S_LAST  in  1  marks the final pair of a transaction.
- S_VALID  in  1  stream valid.
- S_READY  out  1  stream ready.
- VALUES_OUT  out  NUM_INPUTS*WIDTH  packed values; slot i = bits [i*WIDTH +: WIDTH].
- WEIGHTS_OUT  out  NUM_INPUTS*WIDTH  packed weights, same slot layout.
- BIAS_OUT  out  WIDTH  latched bias.
- VALID_OUT  out  1  one-cycle fire pulse to the neuron.
- NEURON_VALUE_IN  in  WIDTH  neuron result.
- NEURON_VALID_IN  in  1  neuron result valid.
- NEURON_OVERFLOW_IN  in  1  neuron overflow flag.
- RESULT  out  WIDTH  captured result.
- RESULT_VALID  out  1  result valid.
- RESULT_READY  in  1  downstream ready.
- RESULT_OVERFLOW  out  1  overflow seen during this transaction.
- RESULT_TIMEOUT  out  1  watchdog expired; constant 0 without the optional feature.
- PROTO_ERR  out  1  sticky stream-framing error.

Behaviour:
- FSM states: LOAD, FIRE, WAIT, PRESENT. Reset state is LOAD.
- Reset clears the beat counter, all vectors, bias, flags and every output. All outputs reset to 0 except S_READY, which is 1 in LOAD.
- Reset mid-transaction discards all partial state; no pulse is issued.
- LOAD:
  - S_READY=1.
  - Each beat with S_VALID&S_READY writes slot idx, then increments idx. Beat 0 also latches S_BIAS.
  - Beat idx=NUM_INPUTS-1 with S_LAST=1: go to FIRE.
  - Early S_LAST (idx<NUM_INPUTS-1): zero-fill remaining slots, go to FIRE. This is legal, not an error.
  - Beat idx=NUM_INPUTS-1 with S_LAST=0: set PROTO_ERR, go to FIRE anyway.
- FIRE:
  - S_READY=0.
  - VALID_OUT=1 for exactly one cycle. VALUES_OUT, WEIGHTS_OUT and BIAS_OUT are stable from this cycle until the next LOAD beat.
  - Clear the overflow accumulator. Go to WAIT.
- WAIT:
  - OR NEURON_OVERFLOW_IN into the accumulator every cycle.
  - On NEURON_VALID_IN, capture NEURON_VALUE_IN into RESULT and go to PRESENT.
  - NEURON_VALID_IN outside WAIT is ignored.
- PRESENT:
  - RESULT_VALID=1; RESULT is held.
  - The overflow accumulator keeps sampling on the first PRESENT cycle, so a flag registered one cycle late is still caught.
  - RESULT_OVERFLOW reflects the accumulator.
  - On RESULT_READY, drop RESULT_VALID, reset idx=0 and return to LOAD; S_READY rises on the next cycle.
- Throughput: one transaction per NUM_INPUTS + 3 + neuron latency cycles, minimum.
- PROTO_ERR is cleared only by reset.

Optional Feature:
- Macro NEURON_DRIVER_TIMEOUT_EN.
- With it: a counter runs in WAIT. Reaching TIMEOUT_CYCLES without NEURON_VALID_IN forces PRESENT with RESULT=0 and RESULT_TIMEOUT=1 until the handshake completes. The counter clears on entry to WAIT.
- Without it: no counter. RESULT_TIMEOUT is tied to 0 and WAIT lasts indefinitely.

Decomposition:
- Shared package holds:
  - the FSM state encoding (2 bits);
  - the slot-index width function ceil(log2(NUM_INPUTS)), minimum 1;
  - the default fixed-point WIDTH and FRAC_BITS constants used across neuron blocks.
- One natural sub-module, neuron_driver_packer: slot-indexed write and zero-fill of the value/weight vectors.

Test Plan:
- NUM_INPUTS=4, WIDTH=8, FRAC_BITS=3. Stream values 8,16,-8,4 and weights 8,8,8,8 with bias 0, S_LAST on beat 3. Expect one VALID_OUT pulse with VALUES_OUT={4,-8,16,8}. With a model neuron returning 0x14 after 3 cycles, expect RESULT=0x14, RESULT_VALID high and RESULT_OVERFLOW=0.
- S_LAST on beat 1 (values 8,8). Expect slots 2-3 equal to 0, VALID_OUT pulses and PROTO_ERR=0.
- No S_LAST on beat 3. Expect PROTO_ERR=1, VALID_OUT still pulses, and PROTO_ERR stays 1 across the next good transaction.
- Hold RESULT_READY=0 for 10 cycles. Expect RESULT stable, S_READY=0 and stream stalled. Release: S_READY=1 one cycle after the handshake.
- Model neuron asserts NEURON_OVERFLOW_IN one cycle after NEURON_VALID_IN. Expect RESULT_OVERFLOW=1. Also drive a spurious NEURON_VALID_IN in LOAD and expect no state change.
- RSTN low mid-LOAD after 2 beats, then a full transaction. Expect no VALID_OUT from the partial data and correct packing afterwards. With NEURON_DRIVER_TIMEOUT_EN and a silent neuron: RESULT_TIMEOUT=1 and RESULT=0 after 64 WAIT cycles.
